// File: rtl/pwm_reg_bank_if.sv
// Request/response register-port bundle between a bus master and pwm_reg_bank.
// Signal names keep the block's original port names.
interface pwm_reg_bank_if #(
  parameter int unsigned ADDR_W = 8
);
  logic              req_valid_i;
  logic              req_ready_o;
  logic              req_we_i;
  logic [ADDR_W-1:0] req_addr_i;
  logic [31:0]       req_wdata_i;
  logic [3:0]        req_wstrb_i;
  logic              resp_valid_o;
  logic              resp_ready_i;
  logic [31:0]       resp_rdata_o;
  logic              resp_err_o;

  modport master (
    output req_valid_i, req_we_i, req_addr_i, req_wdata_i, req_wstrb_i, resp_ready_i,
    input  req_ready_o, resp_valid_o, resp_rdata_o, resp_err_o
  );

  modport slave (
    input  req_valid_i, req_we_i, req_addr_i, req_wdata_i, req_wstrb_i, resp_ready_i,
    output req_ready_o, resp_valid_o, resp_rdata_o, resp_err_o
  );
endinterface

// File: rtl/pwm_reg_bank.sv
// Shadow/active configuration registers for NUM_CH PWM channels. Shadows are written
// over a one-outstanding request/response port; a CTRL write commits shadows to active.
module pwm_reg_bank #(
  parameter int unsigned NUM_CH = 2,
  parameter int unsigned ADDR_W = 8
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  pwm_reg_bank_if.slave         bus,
  output logic [2*NUM_CH-1:0]   pwm_mode_o,
  output logic [32*NUM_CH-1:0]  pwm_period_o,
  output logic [32*NUM_CH-1:0]  pwm_threshold1_o,
  output logic [32*NUM_CH-1:0]  pwm_threshold2_o,
  output logic [12*NUM_CH-1:0]  pwm_step_o
);

  typedef enum logic {S_IDLE, S_RESP} state_e;
  typedef enum logic [2:0] {F_MODE, F_PERIOD, F_THR1, F_THR2, F_STEP, F_CTRL, F_STATUS, F_NONE} field_e;

  state_e state_q, state_d;

  logic [1:0]  sh_mode [NUM_CH];
  logic [31:0] sh_period [NUM_CH];
  logic [31:0] sh_thr1 [NUM_CH];
  logic [31:0] sh_thr2 [NUM_CH];
  logic [11:0] sh_step [NUM_CH];
  logic [1:0]  ac_mode [NUM_CH];
  logic [31:0] ac_period [NUM_CH];
  logic [31:0] ac_thr1 [NUM_CH];
  logic [31:0] ac_thr2 [NUM_CH];
  logic [11:0] ac_step [NUM_CH];
  logic [NUM_CH-1:0] pending_q;

  logic [31:0] rdata_q;
  logic        err_q;

  field_e            fld;
  logic [NUM_CH-1:0] sel;
  logic [ADDR_W-1:0] ch_full;
  logic [31:0]       old_val, merged, ctrl_bits, rd_data;
  logic              err_c, strobe_any, acc, shadow_we;
  logic [NUM_CH-1:0] commit;

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] nw,
                                        input logic [3:0] strb);
    logic [31:0] r;
    for (int unsigned b = 0; b < 4; b++) r[8*b +: 8] = strb[b] ? nw[8*b +: 8] : old[8*b +: 8];
    return r;
  endfunction

  // Handshake FSM
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: if (bus.req_valid_i) state_d = S_RESP;
      S_RESP: if (bus.resp_ready_i) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    bus.req_ready_o  = (state_q == S_IDLE);
    bus.resp_valid_o = (state_q == S_RESP);
    bus.resp_rdata_o = rdata_q;
    bus.resp_err_o   = err_q;
  end

  assign acc = bus.req_valid_i && bus.req_ready_o;

  // Address decode; misaligned addresses never match a field, so they fall into F_NONE.
  always_comb begin
    fld     = F_NONE;
    sel     = '0;
    ch_full = bus.req_addr_i >> 5;
    if (bus.req_addr_i == ADDR_W'(8'h80))      fld = F_CTRL;
    else if (bus.req_addr_i == ADDR_W'(8'h84)) fld = F_STATUS;
    else if (ch_full < ADDR_W'(NUM_CH)) begin
      case (bus.req_addr_i[4:0])
        5'h00:   fld = F_MODE;
        5'h04:   fld = F_PERIOD;
        5'h08:   fld = F_THR1;
        5'h0C:   fld = F_THR2;
        5'h10:   fld = F_STEP;
        default: fld = F_NONE;
      endcase
      for (int unsigned c = 0; c < NUM_CH; c++) sel[c] = (ch_full == ADDR_W'(c));
    end
  end

  always_comb begin
    old_val = '0;
    for (int unsigned c = 0; c < NUM_CH; c++) begin
      if (sel[c]) begin
        case (fld)
          F_MODE:   old_val = {30'b0, sh_mode[c]};
          F_PERIOD: old_val = sh_period[c];
          F_THR1:   old_val = sh_thr1[c];
          F_THR2:   old_val = sh_thr2[c];
          F_STEP:   old_val = {20'b0, sh_step[c]};
          default:  old_val = '0;
        endcase
      end
    end
    strobe_any = |bus.req_wstrb_i;
    merged     = merge(old_val, bus.req_wdata_i, bus.req_wstrb_i);
    ctrl_bits  = merge('0, bus.req_wdata_i, bus.req_wstrb_i);

    err_c = 1'b0;
    if (fld == F_NONE) err_c = 1'b1;
    else if (bus.req_we_i) begin
      if (fld == F_STATUS)                                      err_c = 1'b1;
      else if (fld == F_PERIOD && strobe_any && merged == '0)   err_c = 1'b1;
      else if (fld == F_CTRL && (ctrl_bits >> NUM_CH) != '0)    err_c = 1'b1;
    end

    rd_data = '0;
    if (!bus.req_we_i && !err_c) begin
      case (fld)
        F_STATUS: rd_data = 32'(pending_q);
        F_CTRL:   rd_data = '0;
        default:  rd_data = old_val;
      endcase
    end

    shadow_we = acc && bus.req_we_i && !err_c && strobe_any &&
                (fld != F_CTRL) && (fld != F_STATUS);
    commit    = (acc && bus.req_we_i && !err_c && fld == F_CTRL) ? ctrl_bits[NUM_CH-1:0] : '0;
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      pending_q <= '0;
      for (int unsigned c = 0; c < NUM_CH; c++) begin
        sh_mode[c] <= '0; sh_period[c] <= '0; sh_thr1[c] <= '0; sh_thr2[c] <= '0; sh_step[c] <= '0;
        ac_mode[c] <= '0; ac_period[c] <= '0; ac_thr1[c] <= '0; ac_thr2[c] <= '0; ac_step[c] <= '0;
      end
    end else begin
      for (int unsigned c = 0; c < NUM_CH; c++) begin
        if (shadow_we && sel[c]) begin
          case (fld)
            F_MODE:   sh_mode[c]   <= merged[1:0];
            F_PERIOD: sh_period[c] <= merged;
            F_THR1:   sh_thr1[c]   <= merged;
            F_THR2:   sh_thr2[c]   <= merged;
            F_STEP:   sh_step[c]   <= merged[11:0];
            default:  ;
          endcase
          pending_q[c] <= 1'b1;
        end
        if (commit[c]) begin
          ac_mode[c]   <= sh_mode[c];
          ac_period[c] <= sh_period[c];
          ac_thr1[c]   <= sh_thr1[c];
          ac_thr2[c]   <= sh_thr2[c];
          ac_step[c]   <= sh_step[c];
          pending_q[c] <= 1'b0;
        end
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else if (acc) begin
      rdata_q <= rd_data;
      err_q   <= err_c;
    end else if (state_q == S_RESP && bus.resp_ready_i) begin
      rdata_q <= '0;
      err_q   <= 1'b0;
    end
  end

  always_comb begin
    for (int unsigned c = 0; c < NUM_CH; c++) begin
      pwm_mode_o[2*c +: 2]         = ac_mode[c];
      pwm_period_o[32*c +: 32]     = ac_period[c];
      pwm_threshold1_o[32*c +: 32] = ac_thr1[c];
      pwm_threshold2_o[32*c +: 32] = ac_thr2[c];
      pwm_step_o[12*c +: 12]       = ac_step[c];
    end
  end

endmodule

// File: tb/tb_pwm_reg_bank.sv
// Directed plus randomized bench for pwm_reg_bank with a register-map reference model.
module tb_pwm_reg_bank;
  localparam int NCH = 2;

  logic clk_i = 1'b0;
  logic rst_i = 1'b0;
  always #5 clk_i = ~clk_i;

  pwm_reg_bank_if #(.ADDR_W(8)) bus ();

  logic [2*NCH-1:0]  pwm_mode;
  logic [32*NCH-1:0] pwm_period, pwm_thr1, pwm_thr2;
  logic [12*NCH-1:0] pwm_step;

  pwm_reg_bank #(.NUM_CH(NCH), .ADDR_W(8)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .bus(bus),
    .pwm_mode_o(pwm_mode), .pwm_period_o(pwm_period),
    .pwm_threshold1_o(pwm_thr1), .pwm_threshold2_o(pwm_thr2), .pwm_step_o(pwm_step)
  );

  int checks = 0;
  int failures = 0;

  // Model: field index 0..4 = MODE, PERIOD, THR1, THR2, STEP
  logic [31:0] m_sh  [NCH][5];
  logic [31:0] m_act [NCH][5];
  logic [NCH-1:0] m_pend;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int c = 0; c < NCH; c++)
      for (int f = 0; f < 5; f++) begin m_sh[c][f] = '0; m_act[c][f] = '0; end
    m_pend = '0;
  endtask

  function automatic logic [31:0] field_mask(input int f);
    if (f == 0) return 32'h3;
    if (f == 4) return 32'hFFF;
    return 32'hFFFF_FFFF;
  endfunction

  task automatic model(input bit we, input logic [7:0] a, input logic [31:0] d,
                       input logic [3:0] s, output logic [31:0] rd, output bit er);
    int ch, off, f;
    logic [31:0] bm, nv, b;
    bm = {{8{s[3]}}, {8{s[2]}}, {8{s[1]}}, {8{s[0]}}};
    ch = int'(a) / 32;
    off = int'(a) % 32;
    rd = '0; er = 1'b0;
    if (a == 8'h80) begin
      if (we) begin
        b = d & bm;
        if (b >= (32'd1 << NCH)) er = 1'b1;
        else for (int c = 0; c < NCH; c++)
          if (b[c]) begin
            for (int k = 0; k < 5; k++) m_act[c][k] = m_sh[c][k];
            m_pend[c] = 1'b0;
          end
      end
    end else if (a == 8'h84) begin
      if (we) er = 1'b1; else rd = 32'(m_pend);
    end else if (ch < NCH && off % 4 == 0 && off <= 16) begin
      f = off / 4;
      if (!we) rd = m_sh[ch][f];
      else if (s != 4'b0) begin
        nv = ((m_sh[ch][f] & ~bm) | (d & bm)) & field_mask(f);
        if (f == 1 && nv == '0) er = 1'b1;
        else begin m_sh[ch][f] = nv; m_pend[ch] = 1'b1; end
      end
    end else er = 1'b1;
    if (er) rd = '0;
  endtask

  task automatic chk_out(input string tag);
    logic [63:0] em, ep, e1, e2, es;
    em = '0; ep = '0; e1 = '0; e2 = '0; es = '0;
    for (int c = 0; c < NCH; c++) begin
      em[2*c +: 2]   = m_act[c][0][1:0];
      ep[32*c +: 32] = m_act[c][1];
      e1[32*c +: 32] = m_act[c][2];
      e2[32*c +: 32] = m_act[c][3];
      es[12*c +: 12] = m_act[c][4][11:0];
    end
    chk({tag, "_mode"}, 64'(pwm_mode), em);
    chk({tag, "_period"}, 64'(pwm_period), ep);
    chk({tag, "_thr1"}, 64'(pwm_thr1), e1);
    chk({tag, "_thr2"}, 64'(pwm_thr2), e2);
    chk({tag, "_step"}, 64'(pwm_step), es);
  endtask

  // One transaction; response held for 'hold' cycles while stray requests are offered.
  task automatic xfer(input string tag, input bit we, input logic [7:0] a,
                      input logic [31:0] d, input logic [3:0] s, input int hold);
    logic [31:0] erd;
    bit eer;
    int n;
    @(negedge clk_i);
    bus.req_valid_i = 1'b1; bus.req_we_i = we; bus.req_addr_i = a;
    bus.req_wdata_i = d; bus.req_wstrb_i = s; bus.resp_ready_i = 1'b0;
    n = 0;
    while (bus.req_ready_o !== 1'b1 && n < 50) begin @(negedge clk_i); n++; end
    chk({tag, "_ready_timeout"}, 64'(n < 50), 64'd1);
    @(posedge clk_i);
    model(we, a, d, s, erd, eer);
    #1;
    bus.req_valid_i = 1'b0;
    chk({tag, "_valid"}, 64'(bus.resp_valid_o), 64'd1);
    chk({tag, "_rdata"}, 64'(bus.resp_rdata_o), 64'(erd));
    chk({tag, "_err"}, 64'(bus.resp_err_o), 64'(eer));
    chk_out(tag);
    for (int h = 0; h < hold; h++) begin
      @(negedge clk_i);
      bus.req_valid_i = 1'b1; bus.req_we_i = 1'b1;
      bus.req_addr_i = 8'h80; bus.req_wdata_i = 32'h3; bus.req_wstrb_i = 4'hF;
      chk({tag, "_hold_valid"}, 64'(bus.resp_valid_o), 64'd1);
      chk({tag, "_hold_ready"}, 64'(bus.req_ready_o), 64'd0);
      chk({tag, "_hold_rdata"}, 64'(bus.resp_rdata_o), 64'(erd));
      chk({tag, "_hold_err"}, 64'(bus.resp_err_o), 64'(eer));
    end
    @(negedge clk_i);
    bus.req_valid_i = 1'b0;
    bus.resp_ready_i = 1'b1;
    @(posedge clk_i);
    #1;
    bus.resp_ready_i = 1'b0;
    chk({tag, "_done_valid"}, 64'(bus.resp_valid_o), 64'd0);
    chk({tag, "_done_ready"}, 64'(bus.req_ready_o), 64'd1);
    chk_out({tag, "_done"});
  endtask

  function automatic logic [7:0] rand_addr();
    logic [7:0] offs [8];
    offs = '{8'h00, 8'h04, 8'h08, 8'h0C, 8'h10, 8'h14, 8'h02, 8'h06};
    case ($urandom_range(0, 9))
      0: return 8'h80;
      1: return 8'h84;
      2: return 8'(32'(offs[$urandom_range(0, 7)]) + 32'h20 * $urandom_range(2, 3));
      3: return 8'($urandom);
      default: return 8'(32'(offs[$urandom_range(0, 4)]) + 32'h20 * $urandom_range(0, NCH - 1));
    endcase
  endfunction

  initial begin
    logic [7:0] a;
    logic [31:0] d;
    logic [3:0] s;
    bit we;
    bus.req_valid_i = 1'b0; bus.req_we_i = 1'b0; bus.req_addr_i = '0;
    bus.req_wdata_i = '0; bus.req_wstrb_i = '0; bus.resp_ready_i = 1'b0;
    model_reset();
    repeat (3) @(posedge clk_i);
    #2 rst_i = 1'b1;

    // Reset state
    chk("rst_req_ready", 64'(bus.req_ready_o), 64'd1);
    chk("rst_resp_valid", 64'(bus.resp_valid_o), 64'd0);
    chk("rst_rdata", 64'(bus.resp_rdata_o), 64'd0);
    chk_out("rst");
    xfer("rd_period0", 1'b0, 8'h04, 32'h0, 4'h0, 0);

    // Shadow writes then commit
    xfer("wr_period", 1'b1, 8'h04, 32'd1000, 4'hF, 0);
    xfer("wr_thr1", 1'b1, 8'h08, 32'd250, 4'hF, 0);
    xfer("wr_mode", 1'b1, 8'h00, 32'd1, 4'hF, 0);
    xfer("rd_status1", 1'b0, 8'h84, 32'h0, 4'h0, 0);
    xfer("commit0", 1'b1, 8'h80, 32'h1, 4'hF, 0);
    xfer("rd_status0", 1'b0, 8'h84, 32'h0, 4'h0, 0);

    // Backpressure with stray requests offered
    xfer("bp_read", 1'b0, 8'h04, 32'h0, 4'h0, 5);

    // Errors
    xfer("err_period0", 1'b1, 8'h04, 32'h0, 4'hF, 0);
    xfer("rd_period_kept", 1'b0, 8'h04, 32'h0, 4'h0, 0);
    xfer("err_misalign", 1'b1, 8'h06, 32'h5, 4'hF, 0);
    xfer("err_ch2", 1'b0, 8'h40, 32'h0, 4'h0, 0);
    xfer("err_status_wr", 1'b1, 8'h84, 32'h1, 4'hF, 0);
    xfer("err_ctrl_ch2", 1'b1, 8'h80, 32'h5, 4'hF, 0);
    xfer("nop_strb0", 1'b1, 8'h0C, 32'h1234, 4'h0, 0);

    // Partial strobes, field truncation, dual commit
    xfer("wr_ch1_period", 1'b1, 8'h24, 32'hFFFF_FFFF, 4'h3, 0);
    xfer("rd_ch1_period", 1'b0, 8'h24, 32'h0, 4'h0, 0);
    xfer("wr_ch1_step", 1'b1, 8'h30, 32'hABCD, 4'hF, 0);
    xfer("rd_ch1_step", 1'b0, 8'h30, 32'h0, 4'h0, 0);
    xfer("wr_mode_hi", 1'b1, 8'h20, 32'hFFFF_FFFE, 4'hF, 0);
    xfer("rd_mode_hi", 1'b0, 8'h20, 32'h0, 4'h0, 0);
    xfer("commit_both", 1'b1, 8'h80, 32'h3, 4'hF, 0);
    xfer("rd_ctrl", 1'b0, 8'h80, 32'h0, 4'h0, 0);

    // Randomized traffic
    for (int i = 0; i < 300; i++) begin
      a = rand_addr();
      we = 1'($urandom_range(0, 2) != 0);
      s = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'hF;
      case ($urandom_range(0, 5))
        0: d = 32'h0;
        1: d = 32'($urandom_range(0, 3));
        default: d = $urandom;
      endcase
      xfer("rand", we, a, d, s, $urandom_range(0, 2));
    end

    // Asynchronous reset while a response is outstanding
    @(negedge clk_i);
    bus.req_valid_i = 1'b1; bus.req_we_i = 1'b0; bus.req_addr_i = 8'h04; bus.resp_ready_i = 1'b0;
    @(posedge clk_i);
    #1 bus.req_valid_i = 1'b0;
    chk("arst_pre_valid", 64'(bus.resp_valid_o), 64'd1);
    #2 rst_i = 1'b0;
    model_reset();
    #1;
    chk("arst_valid", 64'(bus.resp_valid_o), 64'd0);
    chk("arst_ready", 64'(bus.req_ready_o), 64'd1);
    chk("arst_rdata", 64'(bus.resp_rdata_o), 64'd0);
    chk_out("arst");
    @(negedge clk_i);
    rst_i = 1'b1;
    xfer("post_rst_rd", 1'b0, 8'h24, 32'h0, 4'h0, 0);
    xfer("post_rst_status", 1'b0, 8'h84, 32'h0, 4'h0, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL global_timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end
endmodule
